cpu_pc_unit: RTL and testbench

- Parametrised next-generation program counter for the RISC-V core fetch stage.
- Adds the following on top of a plain loadable PC register:
  - a configurable reset vector;
  - an internal sequential increment;
  - prioritised next-PC selection: trap, redirect, stall or sequential;
  - detection of misaligned redirect targets;
  - a small circular return-address stack (RAS) for return prediction.
- Sits between the fetch-address mux and instruction memory. It is driven by the control unit and the execute-stage branch resolution.

---
 rtl/cpu_pc_pkg.sv | 42 ++++
 rtl/cpu_return_addr_stack.sv | 77 +++++++
 rtl/cpu_pc_unit.sv | 86 ++++++++
 tb/tb_cpu_pc_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pc_pkg
// Brief    : Shared types, constants and next-PC selection for the PC unit.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pc_pkg;

    // Bytes per instruction and number of low address bits that must be zero.
    localparam int INSTR_BYTES = 4;
    localparam int ALIGN_BITS  = 2;

    typedef enum logic [1:0] {
        PC_SEQ   = 2'd0,
        PC_HOLD  = 2'd1,
        PC_REDIR = 2'd2,
        PC_TRAP  = 2'd3
    } pc_sel_e;

    // Trap beats redirect beats stall. A misaligned redirect is refused and
    // freezes the PC for that cycle rather than falling through to stall/seq.
    function automatic pc_sel_e pc_select(
        input logic trap,
        input logic redirect,
        input logic misaligned,
        input logic stall
    );
        pc_sel_e sel;
        if (trap) begin
            sel = PC_TRAP;
        end else if (redirect && !misaligned) begin
            sel = PC_REDIR;
        end else if (redirect || stall) begin
            sel = PC_HOLD;
        end else begin
            sel = PC_SEQ;
        end
        return sel;
    endfunction

endpackage : cpu_pc_pkg
`default_nettype wire

// File: rtl/cpu_return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : cpu_return_addr_stack
// Brief    : Circular return-address stack with saturating occupancy count.
//            When full, a push overwrites the oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_ptr;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top   = empty ? '0 : mem_q[ptr_q];

    // Next pointer/count and write slot; pointer wraps since depth is 2^n.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q;
        if (push && pop && !empty) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en  = 1'b1;
            wr_ptr = ptr_q;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_ptr = ptr_q + PTR_W'(1);
            ptr_d  = ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= push_addr;
        end
    end

endmodule : cpu_return_addr_stack
`default_nettype wire

// File: rtl/cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pc_unit
// Brief    : Fetch-stage program counter with reset vector, prioritised
//            next-PC selection, misaligned-redirect flag and return stack.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_pc_unit
    import cpu_pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  trap,
    input  logic [ADDR_WIDTH-1:0] trap_vec,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  ras_push,
    input  logic [ADDR_WIDTH-1:0] ras_push_addr,
    input  logic                  ras_pop,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic [ADDR_WIDTH-1:0] ras_top,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  misaligned
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  misaligned_q, misaligned_d;
    logic                  target_unaligned;
    pc_sel_e               pc_sel;
    logic                  ras_op_en;

    assign target_unaligned = (redirect_target[ALIGN_BITS-1:0] != '0);
    assign pc_sel           = pc_select(trap, redirect, target_unaligned, stall);
    assign pc_plus4         = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    assign pc_out           = pc_q;
    assign misaligned       = misaligned_q;

    // Next-PC mux and misalignment flag; a trap suppresses the flag.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = redirect && !trap && target_unaligned;
        case (pc_sel)
            PC_TRAP:  pc_d = trap_vec;
            PC_REDIR: pc_d = redirect_target;
            PC_HOLD:  pc_d = pc_q;
            default:  pc_d = pc_plus4;
        endcase
    end

    // PC and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Stack operations are frozen while stalled or while taking a trap.
    assign ras_op_en = !stall && !trap;

    cpu_return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push && ras_op_en),
        .pop       (ras_pop && ras_op_en),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule : cpu_pc_unit
`default_nettype wire

// File: tb/tb_cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_pc_unit
// Brief    : Self-checking bench: queue-based reference model compared every
//            cycle, plus directed vectors with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_pc_unit;

    localparam int          AW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, stall, trap, redirect, ras_push, ras_pop;
    logic [31:0] trap_vec, redirect_target, ras_push_addr;
    logic [31:0] pc_out, pc_plus4, ras_top;
    logic        ras_empty, ras_full, misaligned;

    int errors = 0;
    int checks = 0;

    cpu_pc_unit #(
        .ADDR_WIDTH   (AW),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .trap            (trap),
        .trap_vec        (trap_vec),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ras_push        (ras_push),
        .ras_push_addr   (ras_push_addr),
        .ras_pop         (ras_pop),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .ras_top         (ras_top),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .misaligned      (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC as plain arithmetic, RAS as a queue (oldest first).
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    = RV;
            m_mis   = 1'b0;
            m_ras.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_mis = redirect && !trap && (redirect_target % 4 != 0);
            if (trap)
                m_pc = trap_vec;
            else if (redirect && (redirect_target % 4 == 0))
                m_pc = redirect_target;
            else if (!redirect && !stall)
                m_pc = m_pc + 32'd4;
            if (!stall && !trap) begin
                if (ras_push && ras_pop && m_ras.size() > 0) begin
                    m_ras[m_ras.size()-1] = ras_push_addr;
                end else if (ras_push) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(ras_push_addr);
                end else if (ras_pop && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
    end

    // Compare DUT against the model every cycle once the model is defined.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc",       pc_out,   m_pc);
            chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("model_mis",      {31'd0, misaligned}, {31'd0, m_mis});
            chk("model_empty",    {31'd0, ras_empty},  {31'd0, m_ras.size() == 0});
            chk("model_full",     {31'd0, ras_full},   {31'd0, m_ras.size() == DEPTH});
            chk("model_top",      ras_top, (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0);
        end
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        stall = 0; trap = 0; redirect = 0; ras_push = 0; ras_pop = 0;
    endtask

    initial begin
        rst = 1; idle();
        trap_vec = '0; redirect_target = '0; ras_push_addr = '0;
        cyc(); cyc();
        chk("rst_pc", pc_out, 32'h100);
        chk("rst_empty", {31'd0, ras_empty}, 32'd1);
        chk("rst_full", {31'd0, ras_full}, 32'd0);
        chk("rst_top", ras_top, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        rst = 0;

        // Free-running increment.
        cyc(); chk("seq1", pc_out, 32'h104);
        cyc(); chk("seq2", pc_out, 32'h108);
        cyc(); chk("seq3", pc_out, 32'h10C);

        // Stall hold, then redirect overriding stall.
        redirect = 1; redirect_target = 32'h200;
        cyc(); chk("redir_200", pc_out, 32'h200);
        redirect = 0; stall = 1;
        cyc(); chk("stall_hold1", pc_out, 32'h200);
        cyc(); chk("stall_hold2", pc_out, 32'h200);
        redirect = 1; redirect_target = 32'h400;
        cyc(); chk("redir_over_stall", pc_out, 32'h400);

        // Trap beats redirect; misaligned redirect holds and pulses.
        stall = 0; trap = 1; trap_vec = 32'h40; redirect_target = 32'h800;
        cyc(); chk("trap_pc", pc_out, 32'h40);
        chk("trap_mis", {31'd0, misaligned}, 32'd0);
        trap = 0; redirect_target = 32'h802;
        cyc(); chk("mis_hold", pc_out, 32'h40);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        redirect = 0;
        cyc(); chk("mis_clear", {31'd0, misaligned}, 32'd0);
        chk("after_mis_pc", pc_out, 32'h44);

        // Address wrap.
        redirect = 1; redirect_target = 32'hFFFF_FFFC;
        cyc(); chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        redirect = 0;
        cyc(); chk("wrap_zero", pc_out, 32'h0);
        chk("wrap_plus4b", pc_plus4, 32'h4);

        // RAS fill and overwrite of the oldest entry.
        ras_push = 1;
        ras_push_addr = 32'hA0; cyc();
        ras_push_addr = 32'hA4; cyc();
        ras_push_addr = 32'hA8; cyc();
        ras_push_addr = 32'hAC; cyc();
        chk("ras_full4", {31'd0, ras_full}, 32'd1);
        chk("ras_top4", ras_top, 32'hAC);
        ras_push_addr = 32'hB0; cyc();
        chk("ras_full5", {31'd0, ras_full}, 32'd1);
        chk("ras_top5", ras_top, 32'hB0);
        ras_push = 0; ras_pop = 1;
        cyc(); chk("pop1", ras_top, 32'hAC);
        cyc(); chk("pop2", ras_top, 32'hA8);
        cyc(); chk("pop3", ras_top, 32'hA4);
        cyc(); chk("pop4_top", ras_top, 32'h0);
        chk("pop4_empty", {31'd0, ras_empty}, 32'd1);
        cyc(); chk("pop5_empty", {31'd0, ras_empty}, 32'd1);
        chk("pop5_top", ras_top, 32'h0);

        // Push+pop on non-empty replaces top; stall and trap gate the stack.
        ras_pop = 0; ras_push = 1; ras_push_addr = 32'h50;
        cyc(); chk("push50", ras_top, 32'h50);
        ras_pop = 1; ras_push_addr = 32'h60;
        cyc(); chk("pp_top", ras_top, 32'h60);
        chk("pp_empty", {31'd0, ras_empty}, 32'd0);
        ras_pop = 0; ras_push_addr = 32'h70; trap = 1; trap_vec = 32'h80;
        cyc(); chk("trap_gate", ras_top, 32'h60);
        chk("trap_gate_pc", pc_out, 32'h80);
        trap = 0; stall = 1;
        cyc(); chk("stall_gate", ras_top, 32'h60);
        ras_push = 0; ras_pop = 1;
        cyc(); chk("stall_gate_pop", ras_top, 32'h60);

        // Mid-sequence reset overrides everything.
        stall = 0; ras_pop = 0; ras_push = 1; ras_push_addr = 32'h90;
        redirect = 1; redirect_target = 32'h1000; rst = 1;
        cyc(); chk("mid_rst_pc", pc_out, 32'h100);
        chk("mid_rst_empty", {31'd0, ras_empty}, 32'd1);
        rst = 0; idle();
        cyc(); chk("post_rst_pc", pc_out, 32'h104);

        // Push+pop on empty acts as a push.
        ras_push = 1; ras_pop = 1; ras_push_addr = 32'h33;
        cyc(); chk("pp_empty_top", ras_top, 32'h33);
        chk("pp_empty_flag", {31'd0, ras_empty}, 32'd0);
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_pc_unit
`default_nettype wire
